reg_op_sequencer: RTL and testbench
===================================

// Module: reg_op_sequencer
// PURPOSE
//  Parametrised control sequencer for the bus-based datapath.
//  - Runs fetch (T0-T2) and register-register ALU execute (T3-T5) as an FSM, driving the one-hot load/drive strobes.
//  - Replaces hand-timed strobes; adds memory-ready and multi-cycle-ALU handshakes, fetch timeout, register-index checking.
// PARAMETERS
//  DATA_W      32  width of instruction word ir_q
//  NUM_REGS    16  general registers; widths of Rin/Rout
//  REG_IDX_W    4  register field width in IR (2**REG_IDX_W >= NUM_REGS)
//  OPC_W        5  opcode field width; also alu_sel width
//  MEM_TIMEOUT 15  max T1 cycles waiting for mem_rdy before error (1..255)
//  CONTINUOUS   0  1: after DONE go straight to T0 while start is high
// PORTS
//  Clock      in  1          rising-edge clock
//  clr        in  1          asynchronous active-low reset
//  start      in  1          request one fetch+execute; sampled in IDLE/DONE
//  ir_q       in  DATA_W     IR contents; opc=[DATA_W-1 -: OPC_W], Ra, Rb, Rc = next three REG_IDX_W fields below opc
//  mem_rdy    in  1          memory read data valid on Mdatain
//  alu_multi  in  1          current opcode needs multi-cycle ALU; sampled in T4
//  alu_done   in  1          multi-cycle ALU result valid in Z
//  PCout,PCin,MARin,MDRin,MDRout,IRin,Yin,Zin,Zlowout,IncPC  out 1  datapath strobes
//  Rin        out NUM_REGS   one-hot register load enable
//  Rout       out NUM_REGS   one-hot register bus drive
//  alu_sel    out OPC_W      ALU operation; opc field in T4 (ADD code 0 in T0), else 0
//  busy       out 1          high in every state except IDLE
//  done       out 1          one-cycle pulse in DONE
//  err        out 1          sticky error: fetch timeout or Rb/Rc/Ra >= NUM_REGS; cleared on next accepted start
//  state      out 4          current state code for debug
// BEHAVIOUR
//  - States/codes: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, DONE=7. Strobes are a Moore decode of the registered state.
//  - Reset (clr=0, async): state=IDLE, err=0, wait counter=0, all outputs 0.
//  - IDLE: all strobes 0; start=1 -> T0 next edge, err cleared.
//  - T0: PCout, MARin, IncPC, Zin=1 (alu_sel=0, ADD; IncPC is the ALU's +1 qualifier on that ADD). Always -> T1.
//  - T1: Zlowout, PCin, MDRin=1.
//    - PCin and MDRin held for every wait cycle; PC reload is idempotent because Z is unchanged.
//    - mem_rdy=1 -> T2.
//    - MEM_TIMEOUT cycles without mem_rdy -> err=1 and DONE; counter resets on entering T1.
//  - T2: MDRout, IRin=1. -> T3. Fields decoded from ir_q in T3 onward (IR loaded at end of T2).
//  - T3: if Ra, Rb or Rc >= NUM_REGS -> err=1 and DONE, no register strobes.
//    Otherwise Rout[Rb]=1, Yin=1 -> T4.
//  - T4: Rout[Rc], Zin=1, alu_sel=opc.
//    - alu_multi=0 -> T5 after one cycle.
//    - alu_multi=1: stay in T4 with strobes held until alu_done=1, then T5. No timeout on the ALU.
//  - T5: Zlowout, Rin[Ra]=1 -> DONE. Ra==Rb or Ra==Rc is legal (read precedes write).
//  - DONE: done=1 for one cycle.
//    - CONTINUOUS=1 and start=1 -> T0, err cleared.
//    - Otherwise -> IDLE.
//  - start outside IDLE/DONE is ignored (no queueing).
//  - Latency: single-cycle op with mem_rdy in first T1 cycle is start edge -> done pulse in 7 cycles (T0..T5, DONE).
//  - Invariants: at most one Rout bit and at most one bus driver (PCout/MDRout/Zlowout/Rout) high in any cycle.
//    Rin and Rout are never both nonzero.
//  - clr low mid-operation: immediate return to IDLE and all strobes low, even inside a wait.
// TESTING
//  1. Reset, start pulse, ir_q=32'h4A920000 (opc=9, Ra=5, Rb=2, Rc=4), mem_rdy=1, alu_multi=0
//     -> states 1..7 on consecutive edges; Rout=16'h0004 in T3, 16'h0010 in T4;
//        Rin=16'h0020 in T5; alu_sel=5'd9 in T4; done at cycle 7.
//  2. mem_rdy held low 3 cycles then high -> T1 lasts 4 cycles with PCin, MDRin high throughout; done at cycle 10; err=0.
//  3. mem_rdy never asserted, MEM_TIMEOUT=15 -> 15 T1 cycles, then DONE with err=1; next start clears err.
//  4. alu_multi=1, alu_done after 5 cycles -> T4 held 6 cycles with Zin, Rout[Rc] stable; then T5 with Rin[Ra].
//  5. NUM_REGS=8, ir_q with Rc=4'hA -> err=1 at T3 exit, Rin and Rout never asserted, done pulse.
//  6. CONTINUOUS=1, start held high -> DONE then T0 back-to-back. clr pulsed low mid-T4
//     -> same-cycle IDLE, all outputs 0, busy=0.

Source files
------------

// File: rtl/reg_op_sequencer_if.sv
// Control/handshake bundle between the op sequencer and the bus datapath.
// The sequencer side uses 'master'; the datapath (or a bench) uses 'slave'.
interface reg_op_sequencer_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5
);
  logic                start;
  logic [DATA_W-1:0]   ir_q;
  logic                mem_rdy;
  logic                alu_multi;
  logic                alu_done;
  logic                PCout;
  logic                PCin;
  logic                MARin;
  logic                MDRin;
  logic                MDRout;
  logic                IRin;
  logic                Yin;
  logic                Zin;
  logic                Zlowout;
  logic                IncPC;
  logic [NUM_REGS-1:0] Rin;
  logic [NUM_REGS-1:0] Rout;
  logic [OPC_W-1:0]    alu_sel;
  logic                busy;
  logic                done;
  logic                err;
  logic [3:0]          state;

  modport master (
    input  start, ir_q, mem_rdy, alu_multi, alu_done,
    output PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, IncPC,
    output Rin, Rout, alu_sel, busy, done, err, state
  );

  modport slave (
    output start, ir_q, mem_rdy, alu_multi, alu_done,
    input  PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, IncPC,
    input  Rin, Rout, alu_sel, busy, done, err, state
  );
endinterface

// File: rtl/reg_op_sequencer.sv
// Fetch + register-register execute sequencer for the single-bus datapath.
// State, error flag and fetch wait counter are registered; strobes decode the state.
module reg_op_sequencer #(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 16,
  parameter int REG_IDX_W   = 4,
  parameter int OPC_W       = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CONTINUOUS  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  reg_op_sequencer_if.master    bus_io
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_DONE
  } state_e;

  localparam int RA_HI = DATA_W - OPC_W - 1;
  localparam int RB_HI = RA_HI - REG_IDX_W;
  localparam int RC_HI = RB_HI - REG_IDX_W;

  state_e               state_q;
  logic                 err_q;
  logic [7:0]           wait_q;

  logic [OPC_W-1:0]     opc;
  logic [REG_IDX_W-1:0] ra;
  logic [REG_IDX_W-1:0] rb;
  logic [REG_IDX_W-1:0] rc;
  logic                 idx_ok;
  logic [NUM_REGS-1:0]  ra_hot;
  logic [NUM_REGS-1:0]  rb_hot;
  logic [NUM_REGS-1:0]  rc_hot;

  assign opc = bus_io.ir_q[DATA_W-1 -: OPC_W];
  assign ra  = bus_io.ir_q[RA_HI -: REG_IDX_W];
  assign rb  = bus_io.ir_q[RB_HI -: REG_IDX_W];
  assign rc  = bus_io.ir_q[RC_HI -: REG_IDX_W];

  assign idx_ok = (32'(ra) < NUM_REGS) && (32'(rb) < NUM_REGS) && (32'(rc) < NUM_REGS);

  // Out-of-range indices match no bit, so the one-hot vectors are simply zero.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_hot
    assign ra_hot[gi] = (32'(ra) == gi);
    assign rb_hot[gi] = (32'(rb) == gi);
    assign rc_hot[gi] = (32'(rc) == gi);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      wait_q  <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus_io.start) begin
            state_q <= S_T0;
            err_q   <= 1'b0;
          end
        end
        S_T0: begin
          state_q <= S_T1;
          wait_q  <= 8'd0;
        end
        S_T1: begin
          if (bus_io.mem_rdy) begin
            state_q <= S_T2;
          end else if (wait_q == 8'(MEM_TIMEOUT - 1)) begin
            state_q <= S_DONE;
            err_q   <= 1'b1;
          end else begin
            wait_q  <= wait_q + 8'd1;
          end
        end
        S_T2: state_q <= S_T3;
        S_T3: begin
          if (idx_ok) begin
            state_q <= S_T4;
          end else begin
            state_q <= S_DONE;
            err_q   <= 1'b1;
          end
        end
        S_T4: begin
          if (!bus_io.alu_multi || bus_io.alu_done) state_q <= S_T5;
        end
        S_T5: state_q <= S_DONE;
        S_DONE: begin
          if ((CONTINUOUS != 0) && bus_io.start) begin
            state_q <= S_T0;
            err_q   <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_io.PCout   = 1'b0;
    bus_io.PCin    = 1'b0;
    bus_io.MARin   = 1'b0;
    bus_io.MDRin   = 1'b0;
    bus_io.MDRout  = 1'b0;
    bus_io.IRin    = 1'b0;
    bus_io.Yin     = 1'b0;
    bus_io.Zin     = 1'b0;
    bus_io.Zlowout = 1'b0;
    bus_io.IncPC   = 1'b0;
    bus_io.Rin     = '0;
    bus_io.Rout    = '0;
    bus_io.alu_sel = '0;
    bus_io.done    = 1'b0;
    case (state_q)
      S_T0: begin
        bus_io.PCout = 1'b1;
        bus_io.MARin = 1'b1;
        bus_io.IncPC = 1'b1;
        bus_io.Zin   = 1'b1;
      end
      S_T1: begin
        bus_io.Zlowout = 1'b1;
        bus_io.PCin    = 1'b1;
        bus_io.MDRin   = 1'b1;
      end
      S_T2: begin
        bus_io.MDRout = 1'b1;
        bus_io.IRin   = 1'b1;
      end
      S_T3: begin
        if (idx_ok) begin
          bus_io.Rout = rb_hot;
          bus_io.Yin  = 1'b1;
        end
      end
      S_T4: begin
        bus_io.Rout    = rc_hot;
        bus_io.Zin     = 1'b1;
        bus_io.alu_sel = opc;
      end
      S_T5: begin
        bus_io.Zlowout = 1'b1;
        bus_io.Rin     = ra_hot;
      end
      S_DONE: bus_io.done = 1'b1;
      default: ;
    endcase
  end

  assign bus_io.busy  = (state_q != S_IDLE);
  assign bus_io.err   = err_q;
  assign bus_io.state = state_q;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed bench for reg_op_sequencer: a 16-register one-shot instance and
// an 8-register continuous instance, with a scoreboard of per-operation results.
module tb_reg_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a;
  logic rst_n_b;

  reg_op_sequencer_if #(.DATA_W(32), .NUM_REGS(16), .OPC_W(5)) ifa ();
  reg_op_sequencer_if #(.DATA_W(32), .NUM_REGS(8),  .OPC_W(5)) ifb ();

  reg_op_sequencer #(.NUM_REGS(16), .CONTINUOUS(0)) dut_a (
    .clk_i   (clk),
    .rst_n_i (rst_n_a),
    .bus_io  (ifa.master)
  );

  reg_op_sequencer #(.NUM_REGS(8), .CONTINUOUS(1)) dut_b (
    .clk_i   (clk),
    .rst_n_i (rst_n_b),
    .bus_io  (ifb.master)
  );

  typedef struct {
    int          lat;
    logic        err;
    int          t1;
    int          t4;
    logic [15:0] rin;
    logic [15:0] rout;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] strobes_a();
    return {ifa.PCout, ifa.PCin, ifa.MARin, ifa.MDRin, ifa.MDRout,
            ifa.IRin, ifa.Yin, ifa.Zin, ifa.Zlowout, ifa.IncPC};
  endfunction

  function automatic logic [9:0] strobes_b();
    return {ifb.PCout, ifb.PCin, ifb.MARin, ifb.MDRin, ifb.MDRout,
            ifb.IRin, ifb.Yin, ifb.Zin, ifb.Zlowout, ifb.IncPC};
  endfunction

  function automatic logic [31:0] ir_word(input int opc, input int ra, input int rb, input int rc);
    return {5'(opc), 4'(ra), 4'(rb), 4'(rc), 15'd0};
  endfunction

  function automatic logic inv_ok(input logic pco, input logic mdro, input logic zlo,
                                  input logic [15:0] rin, input logic [15:0] rout);
    int drivers;
    drivers = int'(pco) + int'(mdro) + int'(zlo) + int'(|rout);
    return (drivers <= 1) && ($countones(rout) <= 1) && !((|rin) && (|rout));
  endfunction

  always @(negedge clk) begin
    if (rst_n_a) check("inv_a", 32'(inv_ok(ifa.PCout, ifa.MDRout, ifa.Zlowout, ifa.Rin, ifa.Rout)), 32'd1);
    if (rst_n_b) check("inv_b", 32'(inv_ok(ifb.PCout, ifb.MDRout, ifb.Zlowout, 16'(ifb.Rin), 16'(ifb.Rout))), 32'd1);
  end

  task automatic compare_sb(input string tag, input int lat, input logic err, input int t1,
                            input int t4, input logic [15:0] rin, input logic [15:0] rout);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sbq.size() > 0), 32'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check({tag, "_latency"}, 32'(lat), 32'(e.lat));
      check({tag, "_err"},     32'(err), 32'(e.err));
      check({tag, "_t1_cyc"},  32'(t1),  32'(e.t1));
      check({tag, "_t4_cyc"},  32'(t4),  32'(e.t4));
      check({tag, "_rin"},     32'(rin), 32'(e.rin));
      check({tag, "_rout"},    32'(rout), 32'(e.rout));
    end
  endtask

  // One operation on the 16-register instance; mem_rdy rises in T1 cycle rdy_delay+1,
  // alu_done rises in T4 cycle alu_delay+1.
  task automatic run_a(input string tag, input logic [31:0] ir, input int rdy_delay,
                       input logic multi, input int alu_delay);
    int          cyc = 0;
    int          t1 = 0;
    int          t4 = 0;
    logic [15:0] rin_or = '0;
    logic [15:0] rout_or = '0;
    bit          seen = 0;
    logic [15:0] ra_hot, rb_hot, rc_hot;
    ra_hot = 16'(1) << ir[26:23];
    rb_hot = 16'(1) << ir[22:19];
    rc_hot = 16'(1) << ir[18:15];
    ifa.ir_q = ir; ifa.alu_multi = multi; ifa.alu_done = 1'b0;
    ifa.mem_rdy = (rdy_delay == 0); ifa.start = 1'b1;
    while (!seen && cyc < 80) begin
      tick();
      cyc++;
      ifa.start = 1'b0;
      if (cyc == 1) begin
        check({tag, "_t0_state"},   32'(ifa.state), 32'd1);
        check({tag, "_t0_strobes"}, 32'(strobes_a()), 32'(10'b1010000101));
        check({tag, "_t0_err_clr"}, 32'(ifa.err), 32'd0);
      end
      if (ifa.state == 4'd2) begin
        t1++;
        check({tag, "_t1_hold"}, 32'({ifa.PCin, ifa.MDRin, ifa.Zlowout}), 32'd7);
      end
      if (ifa.state == 4'd4) check({tag, "_t3_rout"}, 32'(ifa.Rout), 32'(rb_hot));
      if (ifa.state == 4'd5) begin
        t4++;
        check({tag, "_t4_hold"}, 32'({ifa.Zin, ifa.alu_sel, ifa.Rout}), 32'({1'b1, ir[31:27], rc_hot}));
      end
      if (ifa.state == 4'd6) check({tag, "_t5_rin"}, 32'(ifa.Rin), 32'(ra_hot));
      rin_or  |= ifa.Rin;
      rout_or |= ifa.Rout;
      ifa.mem_rdy  = (t1 > rdy_delay);
      ifa.alu_done = (t4 > alu_delay);
      if (ifa.done) seen = 1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    compare_sb(tag, cyc, ifa.err, t1, t4, rin_or, rout_or);
    ifa.mem_rdy = 1'b0; ifa.alu_done = 1'b0;
    tick();
    check({tag, "_back_idle"}, 32'({ifa.state, ifa.busy}), 32'd0);
    $display("[TB] %s: latency %0d err %0d t1 %0d t4 %0d", tag, cyc, ifa.err, t1, t4);
  endtask

  // One operation on the 8-register continuous instance with mem_rdy high and single-cycle ALU.
  task automatic run_b(input string tag, input logic [31:0] ir, input logic hold_start);
    int          cyc = 0;
    int          t1 = 0;
    int          t4 = 0;
    logic [15:0] rin_or = '0;
    logic [15:0] rout_or = '0;
    bit          seen = 0;
    ifb.ir_q = ir; ifb.alu_multi = 1'b0; ifb.alu_done = 1'b0;
    ifb.mem_rdy = 1'b1; ifb.start = 1'b1;
    while (!seen && cyc < 40) begin
      tick();
      cyc++;
      ifb.start = hold_start;
      if (cyc == 1) check({tag, "_t0_err_clr"}, 32'({ifb.state, ifb.err}), 32'({4'd1, 1'b0}));
      if (ifb.state == 4'd2) t1++;
      if (ifb.state == 4'd5) t4++;
      rin_or  |= 16'(ifb.Rin);
      rout_or |= 16'(ifb.Rout);
      if (ifb.done) seen = 1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    compare_sb(tag, cyc, ifb.err, t1, t4, rin_or, rout_or);
    $display("[TB] %s: latency %0d err %0d t1 %0d t4 %0d", tag, cyc, ifb.err, t1, t4);
  endtask

  initial begin
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    ifa.start = 1'b0; ifa.ir_q = '0; ifa.mem_rdy = 1'b0; ifa.alu_multi = 1'b0; ifa.alu_done = 1'b0;
    ifb.start = 1'b0; ifb.ir_q = '0; ifb.mem_rdy = 1'b0; ifb.alu_multi = 1'b0; ifb.alu_done = 1'b0;
    ifa.start = 1'b1;
    tick();
    tick();
    check("reset_state_a", 32'({ifa.state, ifa.busy, ifa.err, ifa.done}), 32'd0);
    check("reset_strobes_a", 32'({strobes_a(), ifa.Rin, ifa.Rout, ifa.alu_sel}), 32'd0);
    check("reset_state_b", 32'({ifb.state, ifb.busy, ifb.err, ifb.done}), 32'd0);
    ifa.start = 1'b0;
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    tick();
    check("idle_no_start", 32'({ifa.state, ifa.busy}), 32'd0);

    sbq.push_back('{7, 1'b0, 1, 1, 16'h0020, 16'h0014});
    run_a("basic", 32'h4A920000, 0, 1'b0, 0);

    sbq.push_back('{10, 1'b0, 4, 1, 16'h0020, 16'h0014});
    run_a("mem_wait3", 32'h4A920000, 3, 1'b0, 0);

    sbq.push_back('{17, 1'b1, 15, 0, 16'h0000, 16'h0000});
    run_a("mem_timeout", 32'h4A920000, 1000, 1'b0, 0);
    check("err_sticky_idle", 32'(ifa.err), 32'd1);

    sbq.push_back('{7, 1'b0, 1, 1, 16'h8000, 16'h0003});
    run_a("after_timeout", ir_word(17, 15, 0, 1), 0, 1'b0, 0);

    sbq.push_back('{12, 1'b0, 1, 6, 16'h0020, 16'h0014});
    run_a("alu_multi", 32'h4A920000, 0, 1'b1, 5);

    sbq.push_back('{7, 1'b0, 1, 1, 16'h0008, 16'h0008});
    run_a("ra_eq_rb_rc", ir_word(1, 3, 3, 3), 0, 1'b0, 0);

    sbq.push_back('{5, 1'b1, 1, 0, 16'h0000, 16'h0000});
    run_b("bad_rc", ir_word(3, 1, 2, 10), 1'b0);
    tick();
    check("bad_rc_idle_err", 32'({ifb.state, ifb.err}), 32'({4'd0, 1'b1}));

    sbq.push_back('{7, 1'b0, 1, 1, 16'h0008, 16'h0006});
    run_b("continuous", ir_word(6, 3, 1, 2), 1'b1);
    tick();
    check("continuous_back_t0", 32'({ifb.state, ifb.busy}), 32'({4'd1, 1'b1}));
    tick(); tick(); tick(); tick();
    check("continuous_in_t4", 32'(ifb.state), 32'd5);
    #2;
    rst_n_b = 1'b0;
    #1;
    check("async_clr_state", 32'({ifb.state, ifb.busy, ifb.done, ifb.err}), 32'd0);
    check("async_clr_strobes", 32'({strobes_b(), ifb.Rin, ifb.Rout, ifb.alu_sel}), 32'd0);
    ifb.start = 1'b0;
    tick();
    rst_n_b = 1'b1;
    tick();
    check("post_clr_idle", 32'({ifb.state, ifb.busy}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
